// File: rtl/ili9341_spi_controller.sv
// ILI9341 panel controller: hardware reset, init command sequence, window setup and
// continuous frame-buffer streaming over an external byte-wide SPI master.
// Optional build macro ILI9341_STATUS_READ_EN compiles in a 0x09 status read after 0x29.
module ili9341_spi_controller #(
  parameter int unsigned SYS_CLK_FREQ = 12000000,
  parameter int unsigned DISPLAY_X    = 320,
  parameter int unsigned DISPLAY_Y    = 240
) (
  input  logic        clk,
  input  logic        dis_reset,
  input  logic        spi_busy,
  input  logic [7:0]  spi_in,
  input  logic [7:0]  mem_in,
  output logic        lcd_reset,
  output logic        dc,
  output logic        spi_start,
  output logic [7:0]  spi_out,
  output logic [31:0] mem_addr,
  output logic [31:0] display_status
);

  function automatic int unsigned at_least_4(input int unsigned v);
    return (v < 4) ? 4 : v;
  endfunction

  localparam int unsigned Hold = at_least_4(SYS_CLK_FREQ / 100000);
  localparam int unsigned Rel  = at_least_4(SYS_CLK_FREQ / 200);
  localparam int unsigned Swr  = at_least_4(SYS_CLK_FREQ / 200);
  localparam int unsigned Slp  = at_least_4(SYS_CLK_FREQ / (1000 / 120));

  localparam logic [15:0] DispX    = 16'(DISPLAY_X);
  localparam logic [15:0] DispY    = 16'(DISPLAY_Y);
  localparam logic [31:0] LastAddr = 32'(DISPLAY_X * DISPLAY_Y * 2 - 1);

  // Sequence ROM layout: init bytes, optional status read, then 11 window/RAMWR bytes.
`ifdef ILI9341_STATUS_READ_EN
  localparam logic [4:0] IdxWin = 5'd13;
`else
  localparam logic [4:0] IdxWin = 5'd7;
`endif
  localparam logic [4:0] IdxRamwr = IdxWin + 5'd10;

  typedef enum logic [2:0] {
    StHwRstHold,
    StHwRstWait,
    StSend,
    StWaitBusyHi,
    StWaitBusyLo,
    StDelay,
    StStream
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [4:0]  rom_idx_q, rom_idx_d;
  logic        streaming_q, streaming_d;
  logic        lcd_reset_q, lcd_reset_d;
  logic        dc_q, dc_d;
  logic        spi_start_q, spi_start_d;
  logic [7:0]  spi_out_q, spi_out_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] status_q, status_d;

  logic [7:0]  rom_byte;
  logic        rom_dc;
  logic [4:0]  win_off;

  assign win_off = rom_idx_q - IdxWin;

  // Sequence ROM: byte and D/C flag for the current index.
  always_comb begin
    rom_byte = 8'h00;
    rom_dc   = 1'b1;
    if (rom_idx_q < IdxWin) begin
      case (rom_idx_q)
        5'd0:    begin rom_byte = 8'h01; rom_dc = 1'b0; end
        5'd1:    begin rom_byte = 8'h11; rom_dc = 1'b0; end
        5'd2:    begin rom_byte = 8'h36; rom_dc = 1'b0; end
        5'd3:    rom_byte = 8'h28;
        5'd4:    begin rom_byte = 8'h3A; rom_dc = 1'b0; end
        5'd5:    rom_byte = 8'h55;
        5'd6:    begin rom_byte = 8'h29; rom_dc = 1'b0; end
`ifdef ILI9341_STATUS_READ_EN
        5'd7:    begin rom_byte = 8'h09; rom_dc = 1'b0; end
`endif
        default: rom_byte = 8'h00;
      endcase
    end else begin
      case (win_off)
        5'd0:    begin rom_byte = 8'h2A; rom_dc = 1'b0; end
        5'd3:    rom_byte = DispX[15:8];
        5'd4:    rom_byte = DispX[7:0];
        5'd5:    begin rom_byte = 8'h2B; rom_dc = 1'b0; end
        5'd8:    rom_byte = DispY[15:8];
        5'd9:    rom_byte = DispY[7:0];
        5'd10:   begin rom_byte = 8'h2C; rom_dc = 1'b0; end
        default: rom_byte = 8'h00;
      endcase
    end
  end

  // Next-state logic for the controller FSM and its registered outputs.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rom_idx_d   = rom_idx_q;
    streaming_d = streaming_q;
    lcd_reset_d = lcd_reset_q;
    dc_d        = dc_q;
    spi_start_d = 1'b0;
    spi_out_d   = spi_out_q;
    mem_addr_d  = mem_addr_q;
    status_d    = status_q;
    unique case (state_q)
      StHwRstHold: begin
        lcd_reset_d = 1'b0;
        timer_d     = timer_q + 32'd1;
        if (timer_q == Hold) begin
          lcd_reset_d = 1'b1;
          timer_d     = '0;
          state_d     = StHwRstWait;
        end
      end
      StHwRstWait: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == Rel) begin
          timer_d = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (!spi_busy) begin
          spi_start_d = 1'b1;
          spi_out_d   = rom_byte;
          dc_d        = rom_dc;
          state_d     = StWaitBusyHi;
        end
      end
      StStream: begin
        // mem_addr has been stable since the previous byte, so mem_in is valid here.
        if (!spi_busy) begin
          spi_start_d = 1'b1;
          spi_out_d   = mem_in;
          dc_d        = 1'b1;
          state_d     = StWaitBusyHi;
        end
      end
      StWaitBusyHi: begin
        if (spi_start_q && streaming_q) begin
          mem_addr_d = (mem_addr_q == LastAddr) ? 32'd0 : mem_addr_q + 32'd1;
        end
        if (spi_busy) state_d = StWaitBusyLo;
      end
      StWaitBusyLo: begin
        if (!spi_busy) begin
          if (streaming_q) begin
            // Address back at 0 means the last pixel byte just went out.
            if (mem_addr_q == 32'd0) begin
              streaming_d = 1'b0;
              rom_idx_d   = IdxWin;
              state_d     = StSend;
            end else begin
              state_d = StStream;
            end
          end else begin
`ifdef ILI9341_STATUS_READ_EN
            // First status data byte is a dummy; the next four form the word.
            if (rom_idx_q >= 5'd9 && rom_idx_q <= 5'd12) begin
              status_d = {status_q[23:0], spi_in};
            end
`endif
            if (rom_idx_q == IdxRamwr) begin
              streaming_d = 1'b1;
              state_d     = StStream;
            end else begin
              rom_idx_d = rom_idx_q + 5'd1;
              state_d   = (rom_idx_q <= 5'd1) ? StDelay : StSend;
            end
          end
        end
      end
      StDelay: begin
        // rom_idx_q already points past the command that needs the delay.
        timer_d = timer_q + 32'd1;
        if (timer_q == ((rom_idx_q == 5'd1) ? Swr : Slp)) begin
          timer_d = '0;
          state_d = StSend;
        end
      end
      default: state_d = StHwRstHold;
    endcase
  end

  // State and output registers; reset aborts any transfer or delay.
  always_ff @(posedge clk or posedge dis_reset) begin
    if (dis_reset) begin
      state_q     <= StHwRstHold;
      timer_q     <= '0;
      rom_idx_q   <= '0;
      streaming_q <= 1'b0;
      lcd_reset_q <= 1'b1;
      dc_q        <= 1'b0;
      spi_start_q <= 1'b0;
      spi_out_q   <= 8'h00;
      mem_addr_q  <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rom_idx_q   <= rom_idx_d;
      streaming_q <= streaming_d;
      lcd_reset_q <= lcd_reset_d;
      dc_q        <= dc_d;
      spi_start_q <= spi_start_d;
      spi_out_q   <= spi_out_d;
      mem_addr_q  <= mem_addr_d;
      status_q    <= status_d;
    end
  end

  assign lcd_reset = lcd_reset_q;
  assign dc        = dc_q;
  assign spi_start = spi_start_q;
  assign spi_out   = spi_out_q;
  assign mem_addr  = mem_addr_q;

`ifdef ILI9341_STATUS_READ_EN
  assign display_status = status_q;
`else
  // Status word is never captured in this build.
  logic [7:0] unused_spi_in;
  assign unused_spi_in  = spi_in;
  assign display_status = status_q;
`endif

endmodule

// File: tb/tb_ili9341_spi_controller.sv
// Directed bench for ili9341_spi_controller with a mock SPI master and mock frame buffer.
module tb_ili9341_spi_controller;

  logic        clk;
  logic        dis_reset;
  logic        spi_busy;
  logic [7:0]  spi_in;
  logic [7:0]  mem_in;
  logic        lcd_reset;
  logic        dc;
  logic        spi_start;
  logic [7:0]  spi_out;
  logic [31:0] mem_addr;
  logic [31:0] display_status;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_start = 0;
  int rise_cyc   = 0;
  logic [1:0] bcnt;

  ili9341_spi_controller #(
    .SYS_CLK_FREQ(1),
    .DISPLAY_X   (3),
    .DISPLAY_Y   (4)
  ) dut (
    .clk           (clk),
    .dis_reset     (dis_reset),
    .spi_busy      (spi_busy),
    .spi_in        (spi_in),
    .mem_in        (mem_in),
    .lcd_reset     (lcd_reset),
    .dc            (dc),
    .spi_start     (spi_start),
    .spi_out       (spi_out),
    .mem_addr      (mem_addr),
    .display_status(display_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix(input logic [31:0] a);
    return 8'(a * 32'd13 + 32'd90);
  endfunction

  // Mock SPI master: busy for 4 cycles per transfer, always returns 0xAA.
  assign spi_in = 8'hAA;
  always @(posedge clk or posedge dis_reset) begin
    if (dis_reset) begin
      spi_busy <= 1'b0;
      bcnt     <= 2'd0;
    end else if (!spi_busy && spi_start) begin
      spi_busy <= 1'b1;
      bcnt     <= 2'd3;
    end else if (spi_busy) begin
      if (bcnt == 2'd0) spi_busy <= 1'b0;
      else bcnt <= bcnt - 2'd1;
    end
  end

  // Mock frame buffer with one cycle of read latency.
  always @(posedge clk) mem_in <= pix(mem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic exp_dc, input logic [7:0] exp_out);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (spi_start) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, " start seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({tag, " dc"}, 32'(dc), 32'(exp_dc));
      check_eq({tag, " spi_out"}, 32'(spi_out), 32'(exp_out));
      last_start = cyc;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " lcd_reset"}, 32'(lcd_reset), 32'd1);
    check_eq({tag, " spi_start"}, 32'(spi_start), 32'd0);
    check_eq({tag, " dc"}, 32'(dc), 32'd0);
    check_eq({tag, " spi_out"}, 32'(spi_out), 32'd0);
    check_eq({tag, " mem_addr"}, mem_addr, 32'd0);
    check_eq({tag, " status"}, display_status, 32'd0);
  endtask

  // Release reset and measure the lcd_reset low pulse, then expect the first command.
  task automatic release_and_check_hwreset(input string tag);
    int low;
    bit fell;
    fell = 1'b0;
    low  = 0;
    dis_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!lcd_reset) begin
        fell = 1'b1;
        break;
      end
    end
    check_eq({tag, " lcd_reset fell"}, 32'(fell), 32'd1);
    while (fell && !lcd_reset && low < 100) begin
      low++;
      @(negedge clk);
    end
    check_eq({tag, " lcd_reset low cycles"}, 32'(low), 32'd4);
    rise_cyc = cyc;
    expect_byte({tag, " swreset"}, 1'b0, 8'h01);
    check_eq({tag, " rel gap > 4"}, 32'(last_start - rise_cyc > 4), 32'd1);
  endtask

  task automatic expect_window(input string tag);
    expect_byte({tag, " caset"}, 1'b0, 8'h2A);
    check_eq({tag, " caset mem_addr"}, mem_addr, 32'd0);
    expect_byte({tag, " xs hi"}, 1'b1, 8'h00);
    expect_byte({tag, " xs lo"}, 1'b1, 8'h00);
    expect_byte({tag, " xe hi"}, 1'b1, 8'h00);
    expect_byte({tag, " xe lo"}, 1'b1, 8'h03);
    expect_byte({tag, " paset"}, 1'b0, 8'h2B);
    expect_byte({tag, " ys hi"}, 1'b1, 8'h00);
    expect_byte({tag, " ys lo"}, 1'b1, 8'h00);
    expect_byte({tag, " ye hi"}, 1'b1, 8'h00);
    expect_byte({tag, " ye lo"}, 1'b1, 8'h04);
    expect_byte({tag, " ramwr"}, 1'b0, 8'h2C);
  endtask

  initial begin
    int prev;
    dis_reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Hardware reset pulse and first command.
    release_and_check_hwreset("boot");
    @(negedge clk);
    check_eq("start one cycle", 32'(spi_start), 32'd0);

    // Init sequence with the two long delays.
    prev = last_start;
    expect_byte("slpout", 1'b0, 8'h11);
    check_eq("swr gap > 4", 32'(last_start - prev > 4), 32'd1);
    prev = last_start;
    expect_byte("madctl", 1'b0, 8'h36);
    check_eq("slp gap > 4", 32'(last_start - prev > 4), 32'd1);
    expect_byte("madctl data", 1'b1, 8'h28);
    expect_byte("colmod", 1'b0, 8'h3A);
    expect_byte("colmod data", 1'b1, 8'h55);
    expect_byte("dispon", 1'b0, 8'h29);

`ifdef ILI9341_STATUS_READ_EN
    expect_byte("rddst", 1'b0, 8'h09);
    for (int i = 0; i < 5; i++) expect_byte("rddst read", 1'b1, 8'h00);
`endif

    // Window setup; status word is visible by the 0x2A start.
    expect_byte("win1 caset", 1'b0, 8'h2A);
`ifdef ILI9341_STATUS_READ_EN
    check_eq("status word", display_status, 32'hAAAA_AAAA);
`else
    check_eq("status word", display_status, 32'h0000_0000);
`endif
    expect_byte("win1 xs hi", 1'b1, 8'h00);
    expect_byte("win1 xs lo", 1'b1, 8'h00);
    expect_byte("win1 xe hi", 1'b1, 8'h00);
    expect_byte("win1 xe lo", 1'b1, 8'h03);
    expect_byte("win1 paset", 1'b0, 8'h2B);
    expect_byte("win1 ys hi", 1'b1, 8'h00);
    expect_byte("win1 ys lo", 1'b1, 8'h00);
    expect_byte("win1 ye hi", 1'b1, 8'h00);
    expect_byte("win1 ye lo", 1'b1, 8'h04);
    expect_byte("win1 ramwr", 1'b0, 8'h2C);

    // Full frame of 3*4*2 bytes streamed from the frame buffer.
    for (int i = 0; i < 24; i++) begin
      expect_byte($sformatf("pix%0d", i), 1'b1, pix(32'(i)));
      check_eq($sformatf("pix%0d mem_addr", i), mem_addr, 32'(i));
    end

    // Wrap back to window setup with address 0.
    expect_window("win2");

    // Reset in the middle of streaming aborts and restarts everything.
    for (int i = 0; i < 3; i++) expect_byte("pix2", 1'b1, pix(32'(i)));
    repeat (2) @(negedge clk);
    dis_reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midstream reset");
    repeat (2) @(negedge clk);
    release_and_check_hwreset("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ili9341_spi_controller.md
ILI9341_SPI_CONTROLLER -- requirements
Module: ili9341_spi_controller

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 12000000, clk frequency in Hz.
REQ-002 SHALL have parameter DISPLAY_X, default 320, column-address end value.
REQ-003 SHALL have parameter DISPLAY_Y, default 240, page-address end value.
REQ-004 SHALL use reset dis_reset, asynchronous, active-high; clock clk.
REQ-005 Ports: clk  in  1  system clock (rising edge).
REQ-006 Ports: dis_reset  in  1  block reset.
REQ-007 Ports: spi_busy  in  1  SPI master transfer in progress.
REQ-008 Ports: spi_in  in  8  byte received by SPI master, valid when spi_busy falls.
REQ-009 Ports: mem_in  in  8  frame-buffer read data, one clk after mem_addr.
REQ-010 Ports: lcd_reset  out  1  panel hardware reset, active-low.
REQ-011 Ports: dc  out  1  0 = command byte, 1 = data byte.
REQ-012 Ports: spi_start  out  1  one-cycle transfer request.
REQ-013 Ports: spi_out  out  8  byte to transmit.
REQ-014 Ports: mem_addr  out  32  frame-buffer byte address.
REQ-015 Ports: display_status  out  32  captured status word.

Function
REQ-016 Timers (cycles) SHALL be: HOLD = max(4, SYS_CLK_FREQ/100000); REL = max(4, SYS_CLK_FREQ/200); SWR = max(4, SYS_CLK_FREQ/200); SLP = max(4, SYS_CLK_FREQ/(1000/120)), integer division.
REQ-017 After reset release, lcd_reset SHALL go low and return high exactly HOLD clk cycles later.
REQ-018 The first spi_start SHALL occur more than REL cycles after lcd_reset rises.
REQ-019 Transfer handshake: spi_start is asserted only while spi_busy=0, for exactly one cycle; spi_out/dc are valid in that cycle and held until spi_busy falls; no new spi_start until spi_busy has risen and fallen.
REQ-020 Sequence SHALL be: cmd 0x01; wait more than SWR cycles; cmd 0x11; wait more than SLP cycles; cmd 0x36, data 0x28; cmd 0x3A, data 0x55; cmd 0x29.
REQ-021 Status read SHALL be: cmd 0x09, then 5 data transfers with spi_out=0x00.
REQ-022 The first status transfer result is discarded; the next 4 spi_in bytes SHALL be shifted into display_status MSB-first.
REQ-023 Window setup SHALL be: cmd 0x2A, data 0x00, 0x00, DISPLAY_X[15:8], DISPLAY_X[7:0]; then cmd 0x2B, data 0x00, 0x00, DISPLAY_Y[15:8], DISPLAY_Y[7:0].
REQ-024 Then cmd 0x2C SHALL be sent, followed by N = DISPLAY_X*DISPLAY_Y*2 data bytes.
REQ-025 Each pixel byte SHALL be taken from mem_in, read at least one cycle after mem_addr is set.
REQ-026 mem_addr SHALL equal the address of the byte being sent in its spi_start cycle, and increment afterwards.
REQ-027 After byte N-1 is sent, mem_addr SHALL wrap to 0 and the FSM SHALL return to the 0x2A window setup (continuous refresh).
REQ-028 FSM states SHALL be: HW_RST_HOLD, HW_RST_WAIT, SEND, WAIT_BUSY_HI, WAIT_BUSY_LO, DELAY, STREAM; a sequence ROM index selects the next byte.

Reset
REQ-029 While dis_reset=1: lcd_reset=1, spi_start=0, dc=0, spi_out=0x00, mem_addr=0, display_status=0, FSM=HW_RST_HOLD, timers cleared.
REQ-030 Reset asserted mid-transfer or mid-delay SHALL abort immediately; the full sequence restarts from REQ-017 on release.

Configuration
REQ-031 Macro ILI9341_STATUS_READ_EN defined: the REQ-021/REQ-022 status read is compiled in.
REQ-032 Macro ILI9341_STATUS_READ_EN undefined: 0x29 is followed directly by 0x2A, and display_status is constant 0.

Verification (SYS_CLK_FREQ=1, DISPLAY_X=3, DISPLAY_Y=4, all timers=4; mock SPI busy ~4 cycles, returns 0xAA; mock memory 1-cycle latency)
REQ-033 Scenario 1: release dis_reset -> lcd_reset low for exactly 4 cycles, then high; first spi_start >4 cycles later, dc=0, spi_out=0x01.
REQ-034 Scenario 2: continue -> 0x11 >4 cycles after 0x01; 0x36 >4 cycles after 0x11; then data 0x28, cmd 0x3A, data 0x55, cmd 0x29 with correct dc.
REQ-035 Scenario 3 (macro defined) -> cmd 0x09, 5 reads, then display_status=0xAAAAAAAA at the 0x2A start.
REQ-036 Scenario 4: window -> 0x2A,00,00,00,03 then 0x2B,00,00,00,04; then 0x2C.
REQ-037 Scenario 5: stream -> 24 data bytes, each spi_out = mem(mem_addr) in its start cycle; mem_addr 0..23, then 0 and 0x2A again.
REQ-038 Scenario 6: pulse dis_reset during stream -> outputs return to reset values; sequence restarts with lcd_reset low for 4 cycles.
